hazard_control_unit: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage CPU (IF/ID/EX/MEM/WB). Keeps a per-register

---
 rtl/hazard_pkg.sv | 74 +++++++
 rtl/hazard_scoreboard.sv | 73 +++++++
 rtl/hazard_control_unit.sv | 212 +++++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and helpers for the pipeline hazard controller.
//   - cond_e      : branch condition encoding used by EX (AL/EQ/LT/NE)
//   - op_class_e  : instruction classes the hazard logic cares about
//   - fsm_e       : flush FSM states
//   - op_class()  : maps an opcode onto its class. The opcode encodings are
//                   passed in so the top can take them from parameters.
//   - cond_met()  : evaluates a branch condition against the ALU flags
package hazard_pkg;

    // Widest opcode the decode helper accepts; narrower opcodes are zero-extended.
    localparam int OPC_W_MAX = 16;

    // Default opcode encodings. Anything not listed is treated as ALU.
    localparam int OPC_NOP    = 0;
    localparam int OPC_LOAD   = 1;
    localparam int OPC_STORE  = 2;
    localparam int OPC_BRANCH = 3;

    typedef enum logic [1:0] {
        COND_AL = 2'd0,
        COND_EQ = 2'd1,
        COND_LT = 2'd2,
        COND_NE = 2'd3
    } cond_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_NOP    = 3'd4
    } op_class_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } fsm_e;

    function automatic op_class_e op_class(
        input logic [OPC_W_MAX-1:0] opc,
        input logic [OPC_W_MAX-1:0] opc_nop,
        input logic [OPC_W_MAX-1:0] opc_load,
        input logic [OPC_W_MAX-1:0] opc_store,
        input logic [OPC_W_MAX-1:0] opc_branch
    );
        op_class_e cls;
        if (opc == opc_nop) begin
            cls = CLS_NOP;
        end else if (opc == opc_load) begin
            cls = CLS_LOAD;
        end else if (opc == opc_store) begin
            cls = CLS_STORE;
        end else if (opc == opc_branch) begin
            cls = CLS_BRANCH;
        end else begin
            cls = CLS_ALU;
        end
        return cls;
    endfunction

    function automatic logic cond_met(input cond_e cond, input logic z, input logic n);
        logic met;
        case (cond)
            COND_AL: met = 1'b1;
            COND_EQ: met = z;
            COND_LT: met = n;
            COND_NE: met = ~z;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register countdown of in-flight writes. Each register holds the number
//   of cycles until its pending result lands in the register file.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     freeze_i              hold every count (memory busy)
//     wr_en_i/wr_addr_i     start tracking a new write to wr_addr_i ...
//     wr_val_i              ... with this many cycles remaining
//     rd_addr_a_i/_b_i      two query ports
//     busy_a_o/busy_b_o     queried register count exceeds BUSY_THRESH
//   A write to a register overrides that register's decrement in the same
//   cycle. Queries see the registered count, so a same-cycle write is not
//   visible to a read until the next cycle.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 4,
    parameter int CNT_W       = 3,
    parameter int BUSY_THRESH = 0,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze_i,
    input  logic                  wr_en_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [CNT_W-1:0]      wr_val_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_a_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_b_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(BUSY_THRESH);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             wr_ok;
    logic             zero_a;
    logic             zero_b;

    // r0 is never tracked when it is hard-wired to zero.
    assign wr_ok  = wr_en_i && !((ZERO_REG_EN != 0) && (wr_addr_i == '0));
    assign zero_a = (ZERO_REG_EN != 0) && (rd_addr_a_i == '0);
    assign zero_b = (ZERO_REG_EN != 0) && (rd_addr_b_i == '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!freeze_i && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
        if (wr_ok) begin
            cnt_d[wr_addr_i] = wr_val_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign busy_a_o = !zero_a && (cnt_q[rd_addr_a_i] > THRESH);
    assign busy_b_o = !zero_b && (cnt_q[rd_addr_b_i] > THRESH);

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Hazard controller for a 5-stage pipeline (IF/ID/EX/MEM/WB).
//   - Tracks in-flight register writes in hazard_scoreboard and stalls IF/ID
//     with a bubble into EX on RAW / load-use hazards.
//   - Freezes the whole pipe while data memory is busy.
//   - Resolves EX branches from the ALU flags and squashes younger
//     instructions for BR_PENALTY cycles via a small flush FSM.
//   - Counts RAW/load-use stall cycles in a saturating counter.
//   Build option: define HAZARD_FWD_EN when the datapath has forwarding;
//   then a register only blocks readers while its result is further away
//   than an ALU result (load-use only). Without it readers wait for the
//   register-file write.
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     id_valid_i, id_opcode_i          instruction in ID and its opcode
//     id_rs1_i/id_rs2_i, id_use_rs*_i  source registers and whether read
//     id_rd_i, id_we_i                 destination register and write enable
//     ex_branch_i, ex_cond_i           branch in EX and its condition
//     flag_z_i, flag_n_i               ALU flags seen by EX
//     mem_busy_i                       data memory not ready
//     stall_if_o, stall_id_o           hold PC/IF-ID and ID
//     bubble_ex_o                      insert NOP into ID/EX
//     flush_if_o, flush_id_o           squash IF/ID and ID/EX
//     take_branch_o                    PC selects branch target
//     stall_cycles_o                   saturating RAW stall-cycle count
//     dbg_state_o                      flush FSM state
//   Handshake: the ID instruction issues in a cycle when id_valid_i is high
//   and none of flush, mem_busy_i or a RAW hazard holds it; otherwise it is
//   either held (stall) or squashed (flush) and never counted as issued.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int REG_ADDR_W  = 4,
    parameter int WB_LAT      = 3,
    parameter int LOAD_EXTRA  = 1,
    parameter int BR_PENALTY  = 2,
    parameter int ZERO_REG_EN = 1,
    parameter int PERF_W      = 16,
    parameter logic [OPCODE_W-1:0] OP_NOP    = OPCODE_W'(OPC_NOP),
    parameter logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(OPC_LOAD),
    parameter logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(OPC_STORE),
    parameter logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(OPC_BRANCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [OPCODE_W-1:0]   id_opcode_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_we_i,
    input  logic                  ex_branch_i,
    input  logic [1:0]            ex_cond_i,
    input  logic                  flag_z_i,
    input  logic                  flag_n_i,
    input  logic                  mem_busy_i,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  bubble_ex_o,
    output logic                  flush_if_o,
    output logic                  flush_id_o,
    output logic                  take_branch_o,
    output logic [PERF_W-1:0]     stall_cycles_o,
    output fsm_e                  dbg_state_o
);

    localparam int CNT_W  = $clog2(WB_LAT + LOAD_EXTRA + 1);
    localparam int FCNT_W = (BR_PENALTY > 2) ? $clog2(BR_PENALTY) : 1;

`ifdef HAZARD_FWD_EN
    // Results closer than an ALU result are reachable through forwarding.
    localparam int BUSY_THRESH = WB_LAT;
`else
    localparam int BUSY_THRESH = 0;
`endif

    fsm_e              state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [FCNT_W-1:0] fcnt_dec;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    op_class_e         cls;
    logic              busy_a;
    logic              busy_b;
    logic              raw;
    logic              raw_stall;
    logic              take;
    logic              flush;
    logic              issue;
    logic              wr_en;
    logic [CNT_W-1:0]  wr_val;

    always_comb begin
        cls = op_class(OPC_W_MAX'(id_opcode_i), OPC_W_MAX'(OP_NOP), OPC_W_MAX'(OP_LOAD),
                       OPC_W_MAX'(OP_STORE), OPC_W_MAX'(OP_BRANCH));
    end

    assign take  = (state_q == ST_IDLE) && ex_branch_i
                   && cond_met(cond_e'(ex_cond_i), flag_z_i, flag_n_i);
    assign flush = (state_q == ST_FLUSH) || take;

    assign raw = id_valid_i && ((id_use_rs1_i && busy_a) || (id_use_rs2_i && busy_b));
    // Only a hazard that actually drives the stall counts; flush and memory
    // busy take precedence over it.
    assign raw_stall = raw && !flush && !mem_busy_i;
    assign issue     = id_valid_i && !flush && !mem_busy_i && !raw;

    // Only ALU and LOAD classes produce a register result.
    assign wr_en  = issue && id_we_i && ((cls == CLS_ALU) || (cls == CLS_LOAD));
    assign wr_val = (cls == CLS_LOAD) ? CNT_W'(WB_LAT + LOAD_EXTRA) : CNT_W'(WB_LAT);

    hazard_scoreboard #(
        .REG_ADDR_W  (REG_ADDR_W),
        .CNT_W       (CNT_W),
        .BUSY_THRESH (BUSY_THRESH),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .freeze_i    (mem_busy_i),
        .wr_en_i     (wr_en),
        .wr_addr_i   (id_rd_i),
        .wr_val_i    (wr_val),
        .rd_addr_a_i (id_rs1_i),
        .rd_addr_b_i (id_rs2_i),
        .busy_a_o    (busy_a),
        .busy_b_o    (busy_b)
    );

    // Flush FSM. The taken-branch cycle itself is the first flush cycle, so
    // FLUSH is held for BR_PENALTY-1 further unfrozen cycles and left on the
    // cycle whose decrement reaches zero.
    assign fcnt_dec = fcnt_q - 1'b1;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take && !mem_busy_i && (BR_PENALTY > 1)) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_W'(BR_PENALTY - 1);
                end
            end
            ST_FLUSH: begin
                if (!mem_busy_i) begin
                    if ((fcnt_q == '0) || (fcnt_dec == '0)) begin
                        state_d = ST_IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_dec;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (raw_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            fcnt_q         <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Outputs are gated by rst_n so they drop the moment reset asserts,
    // regardless of what the pipeline is still presenting on the inputs.
    always_comb begin
        stall_if_o    = 1'b0;
        stall_id_o    = 1'b0;
        bubble_ex_o   = 1'b0;
        flush_if_o    = 1'b0;
        flush_id_o    = 1'b0;
        take_branch_o = 1'b0;
        if (rst_n) begin
            if (flush) begin
                flush_if_o    = 1'b1;
                flush_id_o    = 1'b1;
                take_branch_o = take;
            end else if (mem_busy_i) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
            end else if (raw) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
    import hazard_pkg::*;

    localparam int PERF_W = 4;
    localparam logic [3:0] OP_ALU = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h1;

`ifdef HAZARD_FWD_EN
    localparam int EXP_ALU  = 0;
    localparam int EXP_LOAD = 1;
`else
    localparam int EXP_ALU  = 3;
    localparam int EXP_LOAD = 4;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              id_valid;
    logic [3:0]        id_opcode;
    logic [3:0]        id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2, id_we;
    logic              ex_branch;
    logic [1:0]        ex_cond;
    logic              flag_z, flag_n, mem_busy;
    logic              stall_if, stall_id, bubble_ex, flush_if, flush_id, take_branch;
    logic [PERF_W-1:0] stall_cycles;
    fsm_e              dbg_state;

    hazard_control_unit #(.PERF_W(PERF_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_opcode_i    (id_opcode),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .id_rd_i        (id_rd),
        .id_we_i        (id_we),
        .ex_branch_i    (ex_branch),
        .ex_cond_i      (ex_cond),
        .flag_z_i       (flag_z),
        .flag_n_i       (flag_n),
        .mem_busy_i     (mem_busy),
        .stall_if_o     (stall_if),
        .stall_id_o     (stall_id),
        .bubble_ex_o    (bubble_ex),
        .flush_if_o     (flush_if),
        .flush_id_o     (flush_id),
        .take_branch_o  (take_branch),
        .stall_cycles_o (stall_cycles),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid   = 1'b0;
        id_opcode  = 4'h0;
        id_rs1     = 4'h0;
        id_rs2     = 4'h0;
        id_rd      = 4'h0;
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
        id_we      = 1'b0;
        ex_branch  = 1'b0;
        ex_cond    = 2'd0;
        flag_z     = 1'b0;
        flag_n     = 1'b0;
        mem_busy   = 1'b0;
    endtask

    task automatic drive_issue(input logic [3:0] opc, input logic [3:0] rd);
        set_idle();
        id_valid  = 1'b1;
        id_opcode = opc;
        id_rd     = rd;
        id_we     = 1'b1;
    endtask

    task automatic drive_read(input logic [3:0] rs1, input logic u1,
                              input logic [3:0] rs2, input logic u2);
        set_idle();
        id_valid   = 1'b1;
        id_opcode  = OP_ALU;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
    endtask

    // Counts consecutive stalled cycles of the instruction currently in ID.
    // Returns at a negedge where the instruction is not stalled (or the bound hit).
    task automatic wait_stalls(output int n, output int bub_miss);
        n = 0;
        bub_miss = 0;
        @(negedge clk);
        while (stall_if && (n < 40)) begin
            if (!bubble_ex) bub_miss++;
            n++;
            tick();
            @(negedge clk);
        end
    endtask

    task automatic drain();
        set_idle();
        repeat (6) tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       br;
        logic [1:0] cond;
        logic       z;
        logic       n;
        logic       mb;
        logic       iv;
        logic [3:0] rs1;
        logic       use1;
        logic [5:0] exp;   // {stall_if, stall_id, bubble_ex, flush_if, flush_id, take_branch}
    } vec_t;

    vec_t vecs[12];

    int n, b, base, takes, flushes, stalls, done;

    initial begin
        vecs[0]  = '{"v_idle",      1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000000};
        vecs[1]  = '{"v_br_al",     1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000111};
        vecs[2]  = '{"v_br_eq_z1",  1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000111};
        vecs[3]  = '{"v_br_eq_z0",  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000000};
        vecs[4]  = '{"v_br_lt_n1",  1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000111};
        vecs[5]  = '{"v_br_lt_n0",  1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000000};
        vecs[6]  = '{"v_br_ne_z0",  1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000111};
        vecs[7]  = '{"v_br_ne_z1",  1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000000};
        vecs[8]  = '{"v_mem_busy",  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 6'b110000};
        vecs[9]  = '{"v_mb_and_br", 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 6'b000111};
        vecs[10] = '{"v_no_branch", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 6'b000000};
        vecs[11] = '{"v_read_free", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 6'b000000};

        // ---- reset ----
        set_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, stall_if, stall_id, bubble_ex, flush_if, flush_id, take_branch}, 32'd0);
        chk("reset_perf_state", {27'd0, stall_cycles, dbg_state}, 32'd0);
        tick();
        rst_n = 1'b1;
        drain();

        // ---- table-driven single-cycle vectors from a quiet pipeline ----
        for (int i = 0; i < 12; i++) begin
            drain();
            ex_branch  = vecs[i].br;
            ex_cond    = vecs[i].cond;
            flag_z     = vecs[i].z;
            flag_n     = vecs[i].n;
            mem_busy   = vecs[i].mb;
            id_valid   = vecs[i].iv;
            id_opcode  = OP_ALU;
            id_rs1     = vecs[i].rs1;
            id_use_rs1 = vecs[i].use1;
            @(negedge clk);
            chk(vecs[i].name, {26'd0, stall_if, stall_id, bubble_ex, flush_if, flush_id, take_branch},
                {26'd0, vecs[i].exp});
            tick();
        end
        drain();

        // ---- ALU write r3 then read r3 ----
        base = int'(stall_cycles);
        drive_issue(OP_ALU, 4'd3);
        @(negedge clk);
        chk("alu_issue_nostall", {31'd0, stall_if}, 32'd0);
        tick();
        drive_read(4'd3, 1'b1, 4'd0, 1'b0);
        wait_stalls(n, b);
        tick();
        set_idle();
        chk("alu_use_stall_len", n, EXP_ALU);
        chk("alu_use_bubble_missing", b, 0);
        @(negedge clk);
        chk("alu_use_perf", int'(stall_cycles) - base, EXP_ALU);
        drain();

        // ---- LOAD r5 then use r5 on rs2 ----
        base = int'(stall_cycles);
        drive_issue(OP_LD, 4'd5);
        tick();
        drive_read(4'd0, 1'b0, 4'd5, 1'b1);
        wait_stalls(n, b);
        tick();
        set_idle();
        chk("load_use_stall_len", n, EXP_LOAD);
        chk("load_use_bubble_missing", b, 0);
        @(negedge clk);
        chk("load_use_perf", int'(stall_cycles) - base, EXP_LOAD);
        drain();

        // ---- taken branch EQ with a writer of r7 in ID (must be squashed) ----
        takes = 0; flushes = 0; stalls = 0;
        drive_issue(OP_ALU, 4'd7);
        ex_branch = 1'b1;
        ex_cond   = 2'd1;
        flag_z    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            takes   += int'(take_branch);
            flushes += int'(flush_if & flush_id);
            stalls  += int'(stall_if);
            tick();
            if (k == 0) drive_read(4'd7, 1'b1, 4'd0, 1'b0);
        end
        set_idle();
        chk("br_eq_take_cycles", takes, 1);
        chk("br_eq_flush_cycles", flushes, 2);
        chk("br_squashed_write_stalls", stalls, 0);
        drain();

        // ---- not-taken branch EQ, flag_z=0 ----
        flushes = 0;
        ex_branch = 1'b1;
        ex_cond   = 2'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            flushes += int'(flush_if | flush_id | take_branch);
            tick();
            set_idle();
        end
        chk("br_eq_not_taken", flushes, 0);
        drain();

        // ---- branch taken while a load-use hazard is pending ----
        base = int'(stall_cycles);
        drive_issue(OP_LD, 4'd3);
        tick();
        drive_read(4'd3, 1'b1, 4'd0, 1'b0);
        ex_branch = 1'b1;
        ex_cond   = 2'd0;
        @(negedge clk);
        chk("br_vs_raw_outputs", {26'd0, stall_if, stall_id, bubble_ex, flush_if, flush_id, take_branch},
            {26'd0, 6'b000111});
        tick();
        drain();
        @(negedge clk);
        chk("br_vs_raw_perf", int'(stall_cycles) - base, 0);
        tick();

        // ---- mem_busy for 3 cycles in the middle of a load-use stall ----
        base = int'(stall_cycles);
        drive_issue(OP_LD, 4'd5);
        tick();
        drive_read(4'd5, 1'b1, 4'd0, 1'b0);
        n = 0; done = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done == 0) begin
                mem_busy = (k >= 2) && (k <= 4);
                @(negedge clk);
                if (stall_if) n++;
                else done = 1;
                tick();
            end
        end
        set_idle();
        chk("membusy_stall_len", n, EXP_LOAD + 3);
        @(negedge clk);
        chk("membusy_perf", int'(stall_cycles) - base, EXP_LOAD);
        drain();

        // ---- r0 is hard-wired zero ----
        drive_issue(OP_LD, 4'd0);
        tick();
        drive_read(4'd0, 1'b1, 4'd0, 1'b1);
        wait_stalls(n, b);
        tick();
        chk("r0_no_stall", n, 0);
        drain();

        // ---- reset asserted mid-stall ----
        drive_issue(OP_LD, 4'd9);
        tick();
        drive_read(4'd9, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        chk("rst_pre_stall", {31'd0, stall_if}, 32'd1);
        tick();
        rst_n     = 1'b0;
        ex_branch = 1'b1;
        ex_cond   = 2'd0;
        #1;
        chk("rst_async_outputs", {21'd0, stall_if, stall_id, bubble_ex, flush_if, flush_id, take_branch,
                                  stall_cycles, dbg_state}, 32'd0);
        tick();
        ex_branch = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("rst_no_stall_after", {31'd0, stall_if}, 32'd0);
        tick();
        drain();

        // ---- saturation of stall_cycles (PERF_W=4 -> 15) ----
        for (int i = 0; i < 20; i++) begin
            drive_issue(OP_LD, 4'd4);
            tick();
            drive_read(4'd4, 1'b1, 4'd0, 1'b0);
            wait_stalls(n, b);
            tick();
            set_idle();
        end
        @(negedge clk);
        chk("perf_saturate", {28'd0, stall_cycles}, 32'd15);
        tick();
        drive_issue(OP_LD, 4'd4);
        tick();
        drive_read(4'd4, 1'b1, 4'd0, 1'b0);
        wait_stalls(n, b);
        tick();
        set_idle();
        chk("perf_stall_seen", {31'd0, (n > 0)}, 32'd1);
        @(negedge clk);
        chk("perf_hold", {28'd0, stall_cycles}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
